jk_bank_seq: RTL and testbench
==============================

# jk_bank_seq

Command-driven sequencer for a W-bit register built from the team's JK flip-flop cells. It accepts one command at a time over a valid/ready handshake and drives the bank's per-bit J and K lines to load, clear, count, shift or invert it. It reads the bank's Q outputs back to compute each step. It sits between a control FSM or bus and the JK register bank, and is the only source of J/K for that bank.

## Interface
- W, 4, register bank width (≥2)
- CNT_W, 8, width of repeat-count field
- C  in  1  clock, rising edge; same clock as the JK bank
- R  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at rising C
- cmd_op  in  3  0 NOP, 1 LOAD, 2 CLEAR, 3 INC, 4 DEC, 5 SHL, 6 SHR, 7 INVERT
- cmd_data  in  W  LOAD value; bit 0 is the shift serial-in
- cmd_len  in  CNT_W  step count for INC/DEC/SHL/SHR/INVERT; 0 treated as 1
- q  in  W  bank Q feedback
- j  out  W  registered J lines to bank
- k  out  W  registered K lines to bank
- busy  out  1  ~cmd_ready
- done  out  1  registered one-cycle completion pulse

## Operation
- States: IDLE, DRIVE, SETTLE. On accept, latch op, data and step count: LOAD/CLEAR = 1, others = max(cmd_len, 1).
- IDLE -> DRIVE on accept of any op except NOP. NOP: stay IDLE, pulse done next cycle, j/k unchanged (0).
- DRIVE: j/k hold the step pattern for exactly one C edge. DRIVE -> SETTLE unconditionally. Decrement remaining count.
- SETTLE: j=k=0. If remaining > 0, go to DRIVE with a new pattern computed from the current q. Otherwise go to IDLE with done=1.
- Step patterns, computed from q at the edge entering DRIVE:
  - LOAD: j=d, k=~d.
  - CLEAR: j=0, k=all ones.
  - INC: j=k=t, with t[0]=1 and t[i]=&q[i-1:0].
  - DEC: j=k=t, with t[0]=1 and t[i]=&~q[i-1:0].
  - SHL: target n={q[W-2:0], d[0]}; j=n, k=~n.
  - SHR: target n={d[0], q[W-1:1]}; j=n, k=~n.
  - INVERT: j=k=all ones.
- Arithmetic wraps modulo 2^W unless the saturation feature is compiled in (see Configuration).
- cmd_valid while busy: ignored, not queued. Inputs other than q are sampled only at accept.

## Timing
- Reset, in any state: next edge gives state IDLE, j=0, k=0, done=0, cmd_ready=1, busy=0. Reset mid-command aborts it: no done, no further bank change after the edge on which R is sampled.
- Accept at edge t0. Step s (1..L) drives j/k during cycle t(2s-2)..t(2s-1). The bank updates at edge t(2s-1), and q is valid for the pattern at t(2s).
- Done is high during cycle t(2L)..t(2L+1). cmd_ready is high in that same cycle, so back-to-back accept at t(2L+1) is allowed.
- Throughput: one bank update per 2 cycles.
- NOP: done high during t0..t1; cmd_ready stays high throughout.
- Latency for L steps: 2L cycles from accept to done.

## Configuration
- JK_BANK_SEQ_SATURATE_EN defined:
  - INC with q all ones drives j=k=0; DEC with q all zeros drives j=k=0.
  - The step is still consumed, so timing is unchanged.
- Undefined: INC/DEC wrap.
- All other ops are unaffected in both cases.

## Test plan
The bench uses a W=4 bank of JK cells on C, with set/reset held inactive.
- R high 2 cycles, cmd_valid=1 -> j=0000, k=0000, cmd_ready=1, busy=0, done=0; no accept while R is high.
- LOAD d=1010 from q=0000 -> j=1010, k=0101 for one cycle; q=1010; done 2 cycles after accept; cmd_ready low in between.
- INC len=3 from q=1101 -> q = 1110, 1111, 0000 and done after 6 cycles. With the macro defined: 1110, 1111, 1111, with j=k=0000 on the third step.
- DEC len=2 from q=0001 -> q = 0000, 1111. With the macro defined: 0000, 0000.
- SHL d[0]=1 len=2 from q=0000 -> q = 0001, 0011. A second command held on cmd_valid during busy is accepted exactly at the edge after done rises.
- INC len=5 from q=0000, R asserted during the second SETTLE -> q stays 0010, j=k=0, no done pulse, cmd_ready=1 after the reset edge.

Source files
------------

// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer driving the J/K lines of a W-bit JK flip-flop bank.
// Accepts one command per valid/ready handshake and steps the bank through
// LOAD, CLEAR, INC, DEC, SHL, SHR or INVERT, one bank update every two cycles.
// Optional feature: define JK_BANK_SEQ_SATURATE_EN to make INC/DEC saturate
// instead of wrapping.
// Ports:
//   C          clock (shared with the JK bank)
//   R          synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  high only while idle
//   cmd_op     0 NOP, 1 LOAD, 2 CLEAR, 3 INC, 4 DEC, 5 SHL, 6 SHR, 7 INVERT
//   cmd_data   LOAD value; bit 0 is the shift serial-in
//   cmd_len    step count for INC/DEC/SHL/SHR/INVERT (0 means 1)
//   q          bank Q feedback
//   j, k       registered J/K lines to the bank
//   busy       inverse of cmd_ready
//   done       one-cycle completion pulse
module jk_bank_seq #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [W-1:0]     q,
  output logic [W-1:0]     j,
  output logic [W-1:0]     k,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_INC    = 3'd3;
  localparam logic [2:0] OP_DEC    = 3'd4;
  localparam logic [2:0] OP_SHL    = 3'd5;
  localparam logic [2:0] OP_SHR    = 3'd6;
  localparam logic [2:0] OP_INVERT = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [W-1:0]     d_q;
  logic [CNT_W-1:0] rem_q;
  logic [W-1:0]     j_q, k_q;
  logic             done_q;

  logic [2:0]       op_sel;
  logic [W-1:0]     d_sel;
  logic [W-1:0]     t_inc, t_dec, shl_n, shr_n;
  logic [W-1:0]     pat_j_d, pat_k_d;
  logic [CNT_W-1:0] len_d;

  // Step pattern from live q; the command inputs are used on the accept edge,
  // the latched command on later steps.
  always_comb begin
    op_sel   = (state_q == IDLE) ? cmd_op : op_q;
    d_sel    = (state_q == IDLE) ? cmd_data : d_q;
    t_inc    = '0;
    t_dec    = '0;
    t_inc[0] = 1'b1;
    t_dec[0] = 1'b1;
    for (int i = 1; i < int'(W); i++) begin
      t_inc[i] = t_inc[i-1] & q[i-1];
      t_dec[i] = t_dec[i-1] & ~q[i-1];
    end
`ifdef JK_BANK_SEQ_SATURATE_EN
    // Hold the bank at the rail; the step still consumes its two cycles.
    if (&q)  t_inc = '0;
    if (~|q) t_dec = '0;
`endif
    shl_n   = {q[W-2:0], d_sel[0]};
    shr_n   = {d_sel[0], q[W-1:1]};
    pat_j_d = '0;
    pat_k_d = '0;
    case (op_sel)
      OP_LOAD:   begin pat_j_d = d_sel;  pat_k_d = ~d_sel;  end
      OP_CLEAR:  begin pat_j_d = '0;     pat_k_d = '1;      end
      OP_INC:    begin pat_j_d = t_inc;  pat_k_d = t_inc;   end
      OP_DEC:    begin pat_j_d = t_dec;  pat_k_d = t_dec;   end
      OP_SHL:    begin pat_j_d = shl_n;  pat_k_d = ~shl_n;  end
      OP_SHR:    begin pat_j_d = shr_n;  pat_k_d = ~shr_n;  end
      OP_INVERT: begin pat_j_d = '1;     pat_k_d = '1;      end
      default:   begin pat_j_d = '0;     pat_k_d = '0;      end
    endcase
  end

  // Effective step count latched at accept.
  always_comb begin
    if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) len_d = CNT_W'(1);
    else if (cmd_len == '0)                      len_d = CNT_W'(1);
    else                                         len_d = cmd_len;
  end

  // Sequencer: J/K are driven for one edge, then zero for one settle cycle.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      d_q     <= '0;
      rem_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_NOP) begin
              done_q <= 1'b1;
            end else begin
              op_q    <= cmd_op;
              d_q     <= cmd_data;
              rem_q   <= len_d;
              j_q     <= pat_j_d;
              k_q     <= pat_k_d;
              state_q <= DRIVE;
            end
          end
        end
        DRIVE: begin
          rem_q   <= rem_q - CNT_W'(1);
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (rem_q != '0) begin
            j_q     <= pat_j_d;
            k_q     <= pat_k_d;
            state_q <= DRIVE;
          end else begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// Scoreboard bench for jk_bank_seq driving a behavioural 4-bit JK bank.
module tb_jk_bank_seq;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLEAR = 3'd2, INC = 3'd3;
  localparam logic [2:0] DEC = 3'd4, SHL = 3'd5, SHR = 3'd6, INV = 3'd7;

  logic       C = 1'b0;
  logic       R;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] qb = 4'b0000;
  logic [3:0] j, k;
  logic       busy, done;

  typedef struct {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
  } step_t;

  step_t sq[$];
  int    lq[$];
  int    accq[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    ph_drive = 1'b1;
  step_t cur;

  jk_bank_seq #(.W(4), .CNT_W(8)) dut (
    .C(C), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .q(qb), .j(j), .k(k), .busy(busy), .done(done)
  );

  always #5 C = ~C;

  // JK bank: J sets, K clears, both toggle.
  always @(posedge C) qb <= (j & ~qb) | (~k & qb);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_step(input logic [3:0] sj, input logic [3:0] sk, input logic [3:0] sqv);
    step_t s;
    s.j = sj; s.k = sk; s.q = sqv;
    sq.push_back(s);
  endtask

  // Accept tracker and cycle counter.
  always @(posedge C) begin
    if (R) accq.delete();
    else if (cmd_valid && cmd_ready) accq.push_back(cyc);
    cyc++;
  end

  // Monitor: per-step J/K and resulting Q, plus done latency.
  always @(negedge C) begin
    if (mon_en) begin
      if (busy) begin
        if (ph_drive) begin
          if (sq.size() == 0) begin
            chk("unexpected_step", 32'(j), 32'hFFFF);
          end else begin
            cur = sq.pop_front();
            chk("step_j", 32'(j), 32'(cur.j));
            chk("step_k", 32'(k), 32'(cur.k));
          end
        end else begin
          chk("settle_jk", 32'({j, k}), 32'h0);
          chk("step_q", 32'(qb), 32'(cur.q));
        end
        ph_drive = !ph_drive;
      end else begin
        ph_drive = 1'b1;
        chk("idle_jk", 32'({j, k}), 32'h0);
      end
      if (done) begin
        if (lq.size() == 0 || accq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          chk("done_latency", 32'(cyc - accq.pop_front() - 1), 32'(lq.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [7:0] len,
                      input int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge C);
      n++;
    end
    chk("ready_timeout", 32'(cmd_ready), 32'h1);
    cmd_op = op; cmd_data = d; cmd_len = len; cmd_valid = 1'b1;
    if (lat >= 0) lq.push_back(lat);
    @(posedge C);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    R = 1'b1; cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 4'b1111; cmd_len = 8'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge C);
      chk("rst_j", 32'(j), 32'h0);
      chk("rst_k", 32'(k), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
    end
    R = 1'b0; cmd_valid = 1'b0;
    chk("rst_no_load", 32'(qb), 32'h0);
    mon_en = 1'b1;

    push_step(4'b1010, 4'b0101, 4'b1010);
    send(LOAD, 4'b1010, 8'd0, 2);
    push_step(4'b1101, 4'b0010, 4'b1101);
    send(LOAD, 4'b1101, 8'd0, 2);

`ifdef JK_BANK_SEQ_SATURATE_EN
    push_step(4'b0011, 4'b0011, 4'b1110);
    push_step(4'b0001, 4'b0001, 4'b1111);
    push_step(4'b0000, 4'b0000, 4'b1111);
`else
    push_step(4'b0011, 4'b0011, 4'b1110);
    push_step(4'b0001, 4'b0001, 4'b1111);
    push_step(4'b1111, 4'b1111, 4'b0000);
`endif
    send(INC, 4'b0000, 8'd3, 6);

    push_step(4'b0001, 4'b1110, 4'b0001);
    send(LOAD, 4'b0001, 8'd0, 2);
`ifdef JK_BANK_SEQ_SATURATE_EN
    push_step(4'b0001, 4'b0001, 4'b0000);
    push_step(4'b0000, 4'b0000, 4'b0000);
`else
    push_step(4'b0001, 4'b0001, 4'b0000);
    push_step(4'b1111, 4'b1111, 4'b1111);
`endif
    send(DEC, 4'b0000, 8'd2, 4);

    send(NOP, 4'b1010, 8'd3, 0);
    @(negedge C);
`ifdef JK_BANK_SEQ_SATURATE_EN
    chk("nop_q", 32'(qb), 32'h0);
`else
    chk("nop_q", 32'(qb), 32'hF);
`endif
    chk("nop_ready", 32'(cmd_ready), 32'h1);

    push_step(4'b0000, 4'b1111, 4'b0000);
    send(CLEAR, 4'b1111, 8'd9, 2);

    // SHL with a second command held on cmd_valid while busy.
    push_step(4'b0001, 4'b1110, 4'b0001);
    push_step(4'b0011, 4'b1100, 4'b0011);
    push_step(4'b1111, 4'b1111, 4'b1100);
    while (!cmd_ready) @(negedge C);
    cmd_op = SHL; cmd_data = 4'b0001; cmd_len = 8'd2; cmd_valid = 1'b1;
    lq.push_back(4);
    @(posedge C);
    #1 cmd_op = INV; cmd_data = 4'b0000; cmd_len = 8'd1;
    lq.push_back(2);
    n = 1;
    while (n < 20) begin
      @(negedge C);
      if (cmd_ready) break;
      n++;
    end
    chk("b2b_accept_edge", 32'(n), 32'd5);
    @(posedge C);
    #1 cmd_valid = 1'b0;

    push_step(4'b0110, 4'b1001, 4'b0110);
    send(SHR, 4'b0000, 8'd0, 2);

    push_step(4'b0000, 4'b1111, 4'b0000);
    send(CLEAR, 4'b0000, 8'd0, 2);

    // INC len=5 aborted by reset during the second settle cycle.
    push_step(4'b0001, 4'b0001, 4'b0001);
    push_step(4'b0011, 4'b0011, 4'b0010);
    send(INC, 4'b0000, 8'd5, -1);
    repeat (3) @(posedge C);
    @(negedge C);
    R = 1'b1;
    @(posedge C);
    #1 R = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      chk("abort_q", 32'(qb), 32'h2);
      chk("abort_jk", 32'({j, k}), 32'h0);
      chk("abort_ready", 32'(cmd_ready), 32'h1);
      chk("abort_done", 32'(done), 32'h0);
    end

    n = 0;
    while ((sq.size() != 0 || lq.size() != 0) && n < 50) begin
      @(negedge C);
      n++;
    end
    chk("steps_left", 32'(sq.size()), 32'h0);
    chk("dones_left", 32'(lq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
